// File: rtl/core_seq_ctrl.sv
// ============================================================================
//  Module      : core_seq_ctrl
//  Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and
//                the instruction register, with memory-timeout bus error.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_seq_ctrl #(
    parameter logic [31:0] RST_PC  = 32'h0000_0000,
    parameter int          TIMEOUT = 15,
    parameter int          CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    input  logic [5:0]  ds_ctrl,
    input  logic        alu_zero,
    input  logic [31:0] br_offset,
    output logic        alu_b_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        reg_wen,
    output logic        wb_sel,
    output logic        retire,
    output logic [31:0] instr_cnt,
    output logic        bus_err,
    output logic [2:0]  state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_cnt;
    logic             r_retire;
    logic             r_bus_err;
    logic [CNT_W-1:0] r_wait;

    logic w_retire_now;
    logic w_br_taken;
    logic w_load_instr;
    logic w_wait_inc;

    logic w_branch, w_mem_read, w_mem_write, w_mem2reg, w_alu_src, w_reg_write;
    assign {w_branch, w_mem_read, w_mem_write, w_mem2reg, w_alu_src, w_reg_write} = ds_ctrl;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next       = r_state;
        w_retire_now = 1'b0;
        w_br_taken   = 1'b0;
        w_load_instr = 1'b0;
        w_wait_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    w_next       = S_DECODE;
                    w_load_instr = 1'b1;
                end else if (r_wait == c_timeout) begin
                    w_next = S_ERR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (w_branch) begin
                    w_retire_now = 1'b1;
                    w_br_taken   = alu_zero;
                end else if (w_mem_read || w_mem_write) begin
                    w_next = S_MEM;
                end else if (w_reg_write) begin
                    w_next = S_WB;
                end else begin
                    w_retire_now = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (w_mem_read) w_next = S_WB;
                    else            w_retire_now = 1'b1;
                end else if (r_wait == c_timeout) begin
                    w_next = S_ERR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_WB:    w_retire_now = 1'b1;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
        // run is only consulted when an instruction leaves the pipeline
        if (w_retire_now) w_next = run ? S_FETCH : S_IDLE;
    end

    // Output logic, decoded from the current state only
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_wen   = 1'b0;
        wb_sel    = 1'b0;
        alu_b_sel = 1'b0;
        case (r_state)
            S_FETCH: imem_req = 1'b1;
            S_EXEC:  alu_b_sel = w_alu_src;
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = w_mem_write;
                alu_b_sel = w_alu_src;
            end
            S_WB: begin
                reg_wen   = 1'b1;
                wb_sel    = w_mem2reg;
                alu_b_sel = w_alu_src;
            end
            default: ;
        endcase
    end

    // PC, instruction register, retire bookkeeping and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RST_PC;
            r_instr   <= 32'd0;
            r_cnt     <= 32'd0;
            r_retire  <= 1'b0;
            r_bus_err <= 1'b0;
            r_wait    <= '0;
        end else begin
            r_retire <= w_retire_now;
            if (w_load_instr) r_instr <= imem_rdata;
            if (w_retire_now) begin
                r_pc  <= w_br_taken ? (r_pc + br_offset) : (r_pc + 32'd4);
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_next == S_ERR) r_bus_err <= 1'b1;
            // every state change is an entry, so FETCH/MEM always start from zero
            if (w_next != r_state)  r_wait <= '0;
            else if (w_wait_inc)    r_wait <= r_wait + c_one;
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign retire    = r_retire;
    assign instr_cnt = r_cnt;
    assign bus_err   = r_bus_err;
    assign state     = r_state;

endmodule

`default_nettype wire
